ifetch_queue: RTL
=================

Name: ifetch_queue

Overview:
Instruction fetch front end feeding the decode/execute core. It owns the fetch PC and issues word reads to instruction memory over a valid/ready request channel. It buffers in-order responses, with their PCs, in a DEPTH-entry queue. It presents them to the core over a valid/ready instruction channel. A redirect input (branch/jump) flushes the queue and discards responses that are still in flight.

Parameters:
DEPTH, 4, queue entries and in-flight request limit per epoch; power of two, 2..16.
RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address of request
imem_rsp_valid  input  1  response data valid; in order, no backpressure, earliest 1 cycle after acceptance
imem_rsp_data  input  32  response instruction word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  new fetch PC
instr_valid  output  1  head instruction available
instr_ready  input  1  core consumes head
instr_data  output  32  head instruction word
instr_pc  output  32  PC of head instruction

Behaviour:
- Reset (async assert, sync-released by flop): fetch_pc=RESET_PC, queue empty, drop_cnt=0. imem_req_valid=0, instr_valid=0, instr_data=0, instr_pc=0.
- Queue entries: {pc, data, filled}. Pointers alloc_ptr, fill_ptr, head_ptr wrap mod DEPTH. alloc_cnt = allocated-not-popped entries (0..DEPTH).
- Request: imem_req_valid=(alloc_cnt<DEPTH); imem_req_addr=fetch_pc. On req_fire (valid&&ready): allocate entry at alloc_ptr with pc=fetch_pc, filled=0; fetch_pc+=4, wrapping mod 2^32.
- Response: on imem_rsp_valid, if drop_cnt>0 then drop_cnt-=1 and the data is discarded. Otherwise write data to entry fill_ptr, set filled=1, fill_ptr+=1.
- Output: instr_valid = head entry allocated and filled; instr_data/instr_pc driven from the head entry. On instr_valid&&instr_ready: head_ptr+=1, alloc_cnt-=1.
- Latency: response accepted at cycle N into an empty queue gives instr_valid=1 at N+1. Full queue: no request issued until a pop; a pop at N lets a request issue at N+1.
- Simultaneous alloc+pop: alloc_cnt unchanged. A pop and a fill on the same entry are impossible, because the head must already be filled to pop.
- Redirect (cycle N) has priority over everything:
  - all entries invalidated; alloc_cnt=0; pointers reset to 0; fetch_pc=redirect_pc.
  - drop_cnt_next = drop_cnt + unfilled_alloc + req_fire(N) − rsp_valid(N), where unfilled_alloc = allocated entries with filled=0.
  - a request accepted at N (old PC) is therefore dropped. A pop at N is void.
  - At N+1: instr_valid=0, imem_req_addr=redirect_pc, imem_req_valid=1.
- Back-to-back redirects accumulate drop_cnt with the same formula. drop_cnt width is clog2(2*DEPTH+1) and it never exceeds 2*DEPTH.
- New-epoch requests may issue while drop_cnt>0. In-order responses guarantee that dropped data precedes new data.
- Reset mid-operation: immediate return to reset state; pending memory responses after reset release are the memory's responsibility (the memory is reset together with this block).

Optional Feature:
IFETCH_ALIGN_CHK_EN
- Defined: adds output misalign_err (1 bit, reset 0). A redirect with redirect_pc[1:0]!=0 still flushes normally, but it also sets misalign_err=1 (sticky) and holds imem_req_valid=0. Both conditions clear on the next redirect whose redirect_pc[1:0]==0.
- Undefined: no misalign_err port; redirect_pc[1:0] is ignored and fetch_pc takes {redirect_pc[31:2],2'b00}.

Test Plan:
- Reset release, imem_req_ready=1, memory latency 1, instr_ready=1: requests 0x0,0x4,0x8,... each cycle. instr_pc sequence 0x0,0x4,0x8 with matching data, first instr_valid 2 cycles after first request.
- instr_ready=0, DEPTH=4: exactly 4 requests (0x0..0xC) issued, then imem_req_valid=0. One pop gives next request 0x10 in the following cycle.
- Latency 3, three requests in flight, redirect_pc=0x100: the 3 old responses are discarded. First instr_valid shows instr_pc=0x100 with the data returned for 0x100.
- Redirect in the same cycle as a request fire, a response, and a pop: drop_cnt follows the formula. No stale PC (below 0x100) ever appears on instr_pc.
- imem_req_ready toggling 1/0 pseudo-randomly for 200 cycles with random instr_ready: instr_pc strictly +4 sequential and data matches the memory model.
- With IFETCH_ALIGN_CHK_EN, redirect_pc=0x102: misalign_err=1 next cycle and no requests. Redirect 0x200: misalign_err=0 and request 0x200 issued.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues word fetches, queues in-order responses with their PCs
// and flushes on redirect. Optional misaligned-redirect trap: define IFETCH_ALIGN_CHK_EN.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc
`ifdef IFETCH_ALIGN_CHK_EN
   ,
   output logic        misalign_err
`endif
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned DW  = $clog2(2 * DEPTH + 1);
   localparam int unsigned DSW = DW + 1;

   logic [31:0]      fetch_pc;
   logic [31:0]      pc_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] filled_q;
   logic [PW-1:0]    alloc_ptr;
   logic [PW-1:0]    fill_ptr;
   logic [PW-1:0]    head_ptr;
   logic [CW-1:0]    alloc_cnt;
   logic [CW-1:0]    pend_cnt;
   logic [DW-1:0]    drop_cnt;
   logic [DSW-1:0]   drop_sum;
   logic             run_q;
   logic             hold_q;
   logic [31:0]      redirect_fetch_pc;
   logic             req_fire;
   logic             pop;
   logic             fill;
   logic             drop;

   // run_q keeps the request channel quiet until the first clock after reset release.
   assign imem_req_valid = run_q && !hold_q && (alloc_cnt < CW'(DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign instr_valid = (alloc_cnt != '0) && filled_q[head_ptr];
   assign instr_data  = data_q[head_ptr];
   assign instr_pc    = pc_q[head_ptr];
   assign pop         = instr_valid && instr_ready;

   assign drop = imem_rsp_valid && (drop_cnt != '0);
   assign fill = imem_rsp_valid && (drop_cnt == '0);

   // pend_cnt counts this epoch's accepted-but-unfilled entries; each one becomes a stale
   // response once a redirect hits, as does a request accepted in the redirect cycle.
   assign drop_sum = DSW'(drop_cnt) + DSW'(pend_cnt) + DSW'(req_fire) - DSW'(imem_rsp_valid);

`ifdef IFETCH_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= 1'b0;
      end else if (redirect_valid) begin
         hold_q <= (redirect_pc[1:0] != 2'b00);
      end
   end

   assign misalign_err      = hold_q;
   assign redirect_fetch_pc = redirect_pc;
`else
   logic unused_align;

   assign hold_q            = 1'b0;
   assign unused_align      = ^redirect_pc[1:0];
   assign redirect_fetch_pc = {redirect_pc[31:2], 2'b00};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         fetch_pc  <= RESET_PC;
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         head_ptr  <= '0;
         alloc_cnt <= '0;
         pend_cnt  <= '0;
         drop_cnt  <= '0;
         filled_q  <= '0;
         // NOTE: the small queue storage is reset so instr_data/instr_pc read zero out of reset.
         for (int i = 0; i < int'(DEPTH); i++) begin
            pc_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         run_q <= 1'b1;
         if (redirect_valid) begin
            fetch_pc  <= redirect_fetch_pc;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            head_ptr  <= '0;
            alloc_cnt <= '0;
            pend_cnt  <= '0;
            filled_q  <= '0;
            drop_cnt  <= DW'(drop_sum);
         end else begin
            if (req_fire) begin
               pc_q[alloc_ptr]     <= fetch_pc;
               filled_q[alloc_ptr] <= 1'b0;
               alloc_ptr           <= alloc_ptr + 1'b1;
               fetch_pc            <= fetch_pc + 32'd4;
            end
            // A fill never targets alloc_ptr in the same cycle: that entry is unallocated.
            if (fill) begin
               data_q[fill_ptr]   <= imem_rsp_data;
               filled_q[fill_ptr] <= 1'b1;
               fill_ptr           <= fill_ptr + 1'b1;
            end
            if (drop) begin
               drop_cnt <= drop_cnt - 1'b1;
            end
            if (pop) begin
               head_ptr <= head_ptr + 1'b1;
            end
            alloc_cnt <= alloc_cnt + CW'(req_fire) - CW'(pop);
            pend_cnt  <= pend_cnt + CW'(req_fire) - CW'(fill);
         end
      end
   end

endmodule
